uart_cmd_bridge: RTL and testbench
==================================

Name: uart_cmd_bridge

Overview:
Command controller that sequences the UART wrapper's RX/TX FIFOs and turns byte frames into transactions on a simple register bus.
- Pops command bytes from the UART RX FIFO, decodes read/write frames, and drives the register bus with a req/ack handshake.
- Pushes one response byte per frame into the UART TX FIFO.
- Sits between the UART wrapper and on-chip control registers: it is the only master of the wrapper's rden/wren.

Parameters:
- FRAME_TO, 24'd1200000, cycles allowed between bytes of one frame before the frame is dropped (about 100 ms at 12 MHz).
- BUS_TO, 8'd64, cycles allowed for bus_ack after bus_req before NAK.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx_data  input  8  UART RX FIFO head byte; valid whenever uart_rx_empty=0 (show-ahead).
- uart_rx_empty  input  1  UART RX FIFO empty.
- uart_rden  output  1  one-cycle pop of UART RX FIFO.
- uart_tx_data  output  8  byte to UART TX FIFO.
- uart_wren  output  1  one-cycle push to UART TX FIFO.
- uart_tx_full  input  1  UART TX FIFO full.
- bus_addr  output  8  register address.
- bus_wdata  output  8  write data.
- bus_we  output  1  1=write, 0=read; valid with bus_req.
- bus_req  output  1  held high until bus_ack or bus timeout.
- bus_rdata  input  8  read data, valid in the bus_ack cycle.
- bus_ack  input  1  one-cycle completion strobe.
- busy  output  1  high in any state other than IDLE.
- err_cnt  output  8  saturating count of dropped, NAKed or unknown frames.

Behaviour:
- Reset: state=IDLE; all outputs 0; err_cnt=0; timers 0. Reset mid-frame discards the frame silently and sends no response.
- Frame formats:
  - Write: 0x57 'W', addr, data → response 0x06 (ACK).
  - Read: 0x52 'R', addr → response = read byte.
  - Any other first byte → response 0x15 (NAK), err_cnt+1.
- RX consumption:
  - When uart_rx_empty=0 and no pop is pending, latch uart_rx_data and pulse uart_rden for exactly 1 cycle.
  - After each pop, ignore uart_rx_empty for the next cycle (pop guard) so the FIFO flags can update.
  - Maximum rate: 1 byte per 2 cycles.
- States:
  - IDLE: on byte, 0x57→ADDR (write), 0x52→ADDR (read), else→RESP with 0x15.
  - ADDR: on byte, latch bus_addr; write→DATA, read→BUS.
  - DATA: on byte, latch bus_wdata; →BUS.
  - BUS: bus_req=1 with bus_we per command. On bus_ack, response=0x06 (write) or bus_rdata (read); →RESP.
    - If BUS_TO cycles pass without ack, drop bus_req, response=0x15, err_cnt+1; →RESP.
    - bus_req falls the cycle after ack.
  - RESP: wait for uart_tx_full=0, pulse uart_wren 1 cycle with uart_tx_data=response; →IDLE.
    - uart_tx_data holds its value until the next push.
- Frame timeout:
  - In ADDR or DATA, a counter restarts on every accepted byte.
  - Reaching FRAME_TO → IDLE, no response, err_cnt+1.
  - The counter does not run in IDLE, BUS or RESP.
- RX bytes arriving in BUS or RESP remain in the UART RX FIFO; they are not popped until IDLE.
- err_cnt saturates at 0xFF.
- Simultaneous bus_ack and bus timeout expiry in the same cycle: ack wins.

Optional Feature:
- Macro UART_CMD_BRIDGE_STATUS_EN.
- Defined: first byte 0x53 'S' is a one-byte frame.
  - Response = err_cnt as it was before the frame; err_cnt then clears to 0 in the RESP push cycle.
  - No bus access.
- Undefined: 0x53 is an unknown command and gets NAK 0x15, err_cnt+1.

Test Plan:
- RX bytes 57,10,A5 → one bus write with addr=0x10, wdata=0xA5, we=1; ack after 3 cycles → TX byte 0x06; err_cnt=0; 3 rden pulses total.
- RX bytes 52,22; bus_rdata=0x3C with ack → bus_we=0, addr=0x22; TX byte 0x3C; busy returns 0 one cycle after wren.
- RX byte 41 → TX byte 0x15, err_cnt=1, no bus_req.
- RX bytes 57,10 then silence for FRAME_TO (bench uses FRAME_TO=100) → state IDLE, no TX push, err_cnt+1; next frame 52,00 is processed normally.
- Read with bus_ack never asserted (BUS_TO=64) → bus_req high exactly 64 cycles, then TX 0x15, err_cnt+1. Then hold uart_tx_full=1 for 50 cycles → no wren until full drops.
- With UART_CMD_BRIDGE_STATUS_EN and err_cnt=3: RX 53 → TX 0x03, err_cnt=0. Without the macro: RX 53 → TX 0x15, err_cnt=4.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// Byte-frame command bridge between a UART wrapper's RX/TX FIFOs and a req/ack register bus.
// Define UART_CMD_BRIDGE_STATUS_EN to add the one-byte 'S' status frame (read and clear err_cnt).
module uart_cmd_bridge #(
   parameter logic [23:0] FRAME_TO = 24'd1200000,
   parameter logic [7:0]  BUS_TO   = 8'd64
) (
   input  logic       CLK,
   input  logic       rst,
   input  logic [7:0] uart_rx_data,
   input  logic       uart_rx_empty,
   output logic       uart_rden,
   output logic [7:0] uart_tx_data,
   output logic       uart_wren,
   input  logic       uart_tx_full,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_wdata,
   output logic       bus_we,
   output logic       bus_req,
   input  logic [7:0] bus_rdata,
   input  logic       bus_ack,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam logic [7:0] CmdWrite  = 8'h57;
   localparam logic [7:0] CmdRead   = 8'h52;
   localparam logic [7:0] RspAck    = 8'h06;
   localparam logic [7:0] RspNak    = 8'h15;
`ifdef UART_CMD_BRIDGE_STATUS_EN
   localparam logic [7:0] CmdStatus = 8'h53;
`endif

   typedef enum logic [2:0] {StIdle, StAddr, StData, StBus, StResp} state_e;

   state_e      state_q, state_d;
   logic        is_write_q, is_write_d;
   logic        clr_err_q, clr_err_d;
   logic        guard_q;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  resp_q, resp_d;
   logic [7:0]  tx_hold_q, tx_hold_d;
   logic [7:0]  err_q, err_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [23:0] frame_cnt_q, frame_cnt_d;
   logic [7:0]  bus_cnt_q, bus_cnt_d;
   logic        take;
   logic        push;
   logic        err_inc;

   // A byte is consumed in the same cycle rden is high; the guard skips the following cycle.
   assign take = (state_q == StIdle || state_q == StAddr || state_q == StData) &&
                 !uart_rx_empty && !guard_q;
   assign push = (state_q == StResp) && !uart_tx_full;

   assign uart_rden    = take;
   assign uart_wren    = push;
   assign uart_tx_data = push ? resp_q : tx_hold_q;
   assign bus_addr     = addr_q;
   assign bus_wdata    = wdata_q;
   assign bus_we       = we_q;
   assign bus_req      = req_q;
   assign busy         = (state_q != StIdle);
   assign err_cnt      = err_q;

   always_comb begin
      state_d     = state_q;
      is_write_d  = is_write_q;
      clr_err_d   = clr_err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      resp_d      = resp_q;
      tx_hold_d   = tx_hold_q;
      req_d       = req_q;
      we_d        = we_q;
      frame_cnt_d = frame_cnt_q;
      bus_cnt_d   = bus_cnt_q;
      err_d       = err_q;
      err_inc     = 1'b0;
      case (state_q)
         StIdle: begin
            if (take) begin
               frame_cnt_d = '0;
               clr_err_d   = 1'b0;
               if (uart_rx_data == CmdWrite) begin
                  is_write_d = 1'b1;
                  state_d    = StAddr;
               end else if (uart_rx_data == CmdRead) begin
                  is_write_d = 1'b0;
                  state_d    = StAddr;
`ifdef UART_CMD_BRIDGE_STATUS_EN
               end else if (uart_rx_data == CmdStatus) begin
                  resp_d    = err_q;
                  clr_err_d = 1'b1;
                  state_d   = StResp;
`endif
               end else begin
                  resp_d  = RspNak;
                  err_inc = 1'b1;
                  state_d = StResp;
               end
            end
         end
         StAddr: begin
            if (take) begin
               addr_d      = uart_rx_data;
               frame_cnt_d = '0;
               if (is_write_q) begin
                  state_d = StData;
               end else begin
                  state_d   = StBus;
                  req_d     = 1'b1;
                  we_d      = 1'b0;
                  bus_cnt_d = '0;
               end
            end else if (frame_cnt_q == FRAME_TO - 24'd1) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end else begin
               frame_cnt_d = frame_cnt_q + 24'd1;
            end
         end
         StData: begin
            if (take) begin
               wdata_d     = uart_rx_data;
               frame_cnt_d = '0;
               state_d     = StBus;
               req_d       = 1'b1;
               we_d        = 1'b1;
               bus_cnt_d   = '0;
            end else if (frame_cnt_q == FRAME_TO - 24'd1) begin
               state_d = StIdle;
               err_inc = 1'b1;
            end else begin
               frame_cnt_d = frame_cnt_q + 24'd1;
            end
         end
         StBus: begin
            // Ack is tested first so it wins over a timeout expiring in the same cycle.
            if (bus_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               resp_d  = is_write_q ? RspAck : bus_rdata;
               state_d = StResp;
            end else if (bus_cnt_q == BUS_TO - 8'd1) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               resp_d  = RspNak;
               err_inc = 1'b1;
               state_d = StResp;
            end else begin
               bus_cnt_d = bus_cnt_q + 8'd1;
            end
         end
         StResp: begin
            if (push) begin
               tx_hold_d = resp_q;
               state_d   = StIdle;
               if (clr_err_q) begin
                  err_d = '0;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (err_inc && err_q != 8'hFF) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         is_write_q  <= 1'b0;
         clr_err_q   <= 1'b0;
         guard_q     <= 1'b1;  // keeps rden low while reset is held
         addr_q      <= '0;
         wdata_q     <= '0;
         resp_q      <= '0;
         tx_hold_q   <= '0;
         err_q       <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         frame_cnt_q <= '0;
         bus_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         is_write_q  <= is_write_d;
         clr_err_q   <= clr_err_d;
         guard_q     <= take;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         resp_q      <= resp_d;
         tx_hold_q   <= tx_hold_d;
         err_q       <= err_d;
         req_q       <= req_d;
         we_q        <= we_d;
         frame_cnt_q <= frame_cnt_d;
         bus_cnt_q   <= bus_cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: frame-level reference model, RX FIFO and bus slave models.
module tb_uart_cmd_bridge;

   localparam int FrameTo = 100;
   localparam int BusTo   = 64;
   localparam int Never   = 255;

   logic       clk           = 1'b0;
   logic       rst           = 1'b1;
   logic [7:0] uart_rx_data  = 8'h00;
   logic       uart_rx_empty = 1'b1;
   logic       uart_rden;
   logic [7:0] uart_tx_data;
   logic       uart_wren;
   logic       uart_tx_full  = 1'b0;
   logic [7:0] bus_addr;
   logic [7:0] bus_wdata;
   logic       bus_we;
   logic       bus_req;
   logic [7:0] bus_rdata     = 8'h00;
   logic       bus_ack       = 1'b0;
   logic       busy;
   logic [7:0] err_cnt;

   uart_cmd_bridge #(
      .FRAME_TO(24'd100),
      .BUS_TO  (8'd64)
   ) dut (
      .CLK          (clk),
      .rst          (rst),
      .uart_rx_data (uart_rx_data),
      .uart_rx_empty(uart_rx_empty),
      .uart_rden    (uart_rden),
      .uart_tx_data (uart_tx_data),
      .uart_wren    (uart_wren),
      .uart_tx_full (uart_tx_full),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_we       (bus_we),
      .bus_req      (bus_req),
      .bus_rdata    (bus_rdata),
      .bus_ack      (bus_ack),
      .busy         (busy),
      .err_cnt      (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] err;
   } tx_exp_t;

   typedef struct packed {
      logic [7:0] addr;
      logic       we;
      logic [7:0] wdata;
   } bus_exp_t;

   tx_exp_t    tx_q[$];
   bus_exp_t   bus_q[$];
   logic [7:0] rx_fifo[$];
   logic [7:0] model_mem[256];
   logic [7:0] slave_mem[256];
   int         model_err = 0;
   int         cur_delay = 0;
   int         checks    = 0;
   int         errors    = 0;
   int         rden_cnt  = 0;
   bit         full_force = 1'b0;
   bit         full_rand  = 1'b0;
   bit         rx_pop     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // RX FIFO model (show-ahead); pops take effect just after the edge that consumed the byte.
   always begin
      @(negedge clk);
      rx_pop = uart_rden;
      if (uart_rden) begin
         rden_cnt++;
         check("rden_with_data", rx_fifo.size() != 0, 1);
      end
      @(posedge clk);
      #1;
      if (rx_pop && rx_fifo.size() != 0) void'(rx_fifo.pop_front());
      uart_rx_empty = (rx_fifo.size() == 0);
      uart_rx_data  = (rx_fifo.size() == 0) ? 8'h00 : rx_fifo[0];
   end

   always begin
      @(posedge clk);
      #1;
      uart_tx_full = full_force || (full_rand && ($urandom_range(0, 3) == 0));
   end

   // TX monitor: every push is matched against the scoreboard in order.
   bit busy_chk = 1'b0;
   always begin
      tx_exp_t e;
      @(negedge clk);
      if (busy_chk) begin
         check("busy_after_wren", busy, 0);
         busy_chk = 1'b0;
      end
      if (uart_wren) begin
         check("wren_while_full", uart_tx_full, 0);
         check("busy_in_wren", busy, 1);
         check("tx_expected", tx_q.size() != 0, 1);
         if (tx_q.size() != 0) begin
            e = tx_q.pop_front();
            check("tx_data", uart_tx_data, e.data);
            check("err_at_push", err_cnt, e.err);
         end
         busy_chk = 1'b1;
      end
   end

   // Bus slave: acks on the (cur_delay+1)-th request cycle, checks request and its length.
   int req_len = 0;
   int exp_len = 0;
   int ack_at  = 0;
   bit acked   = 1'b0;
   always begin
      bus_exp_t b;
      @(negedge clk);
      bus_ack = 1'b0;
      if (rst) begin
         req_len = 0;
         acked   = 1'b0;
      end else if (bus_req) begin
         if (req_len == 0) begin
            check("bus_req_expected", bus_q.size() != 0, 1);
            if (bus_q.size() != 0) begin
               b = bus_q.pop_front();
               check("bus_addr", bus_addr, b.addr);
               check("bus_we", bus_we, b.we);
               if (b.we) check("bus_wdata", bus_wdata, b.wdata);
            end
            exp_len = (cur_delay < BusTo) ? cur_delay + 1 : BusTo;
            ack_at  = cur_delay + 1;
         end
         req_len++;
         if (!acked && req_len == ack_at) begin
            if (bus_we) slave_mem[bus_addr] = bus_wdata;
            bus_rdata = slave_mem[bus_addr];
            bus_ack   = 1'b1;
            acked     = 1'b1;
         end
      end else if (req_len != 0) begin
         check("bus_req_len", req_len, exp_len);
         req_len = 0;
         acked   = 1'b0;
      end
   end

   task automatic bump_err();
      if (model_err < 255) model_err++;
   endtask

   task automatic expect_tx(input logic [7:0] d);
      tx_exp_t e;
      e.data = d;
      e.err  = model_err[7:0];
      tx_q.push_back(e);
   endtask

   task automatic expect_bus(input logic [7:0] a, input logic we, input logic [7:0] wd);
      bus_exp_t b;
      b.addr  = a;
      b.we    = we;
      b.wdata = wd;
      bus_q.push_back(b);
   endtask

   // Frame-level reference: kind 0 = write, 1 = read, other = single command byte d.
   task automatic issue_frame(input int kind, input logic [7:0] a, input logic [7:0] d,
                              input int delay);
      cur_delay = delay;
      if (kind == 0) begin
         expect_bus(a, 1'b1, d);
         if (delay < BusTo) begin
            model_mem[a] = d;
            expect_tx(8'h06);
         end else begin
            bump_err();
            expect_tx(8'h15);
         end
         rx_fifo.push_back(8'h57);
         rx_fifo.push_back(a);
         rx_fifo.push_back(d);
      end else if (kind == 1) begin
         expect_bus(a, 1'b0, 8'h00);
         if (delay < BusTo) begin
            expect_tx(model_mem[a]);
         end else begin
            bump_err();
            expect_tx(8'h15);
         end
         rx_fifo.push_back(8'h52);
         rx_fifo.push_back(a);
      end else begin
`ifdef UART_CMD_BRIDGE_STATUS_EN
         if (d == 8'h53) begin
            expect_tx(model_err[7:0]);
            model_err = 0;
         end else
`endif
         begin
            bump_err();
            expect_tx(8'h15);
         end
         rx_fifo.push_back(d);
      end
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((rx_fifo.size() != 0 || busy || tx_q.size() != 0) && n < budget);
      check(name, (rx_fifo.size() == 0 && !busy && tx_q.size() == 0) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_frame(input int kind, input logic [7:0] a, input logic [7:0] d,
                            input int delay);
      issue_frame(kind, a, d, delay);
      wait_done(600, "frame_done");
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rden", uart_rden, 0);
      check("rst_wren", uart_wren, 0);
      check("rst_tx_data", uart_tx_data, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_err_cnt", err_cnt, 0);
      model_err = 0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int r0;
      logic [7:0] a, d;
      int kind, r, dly;
      for (int i = 0; i < 256; i++) begin
         d = 8'($urandom);
         model_mem[i] = d;
         slave_mem[i] = d;
      end
      apply_reset();

      // Write 57,10,A5 acked after 3 cycles.
      r0 = rden_cnt;
      run_frame(0, 8'h10, 8'hA5, 3);
      check("write_rden_pulses", rden_cnt - r0, 3);
      check("write_err", err_cnt, model_err[7:0]);

      // Read 52,22 returning 3C.
      model_mem[8'h22] = 8'h3C;
      slave_mem[8'h22] = 8'h3C;
      run_frame(1, 8'h22, 8'h00, 2);

      // Unknown command.
      run_frame(2, 8'h00, 8'h41, 0);
      check("unknown_err", err_cnt, model_err[7:0]);

      // Partial frame then silence: dropped without response.
      rx_fifo.push_back(8'h57);
      rx_fifo.push_back(8'h10);
      bump_err();
      repeat (FrameTo + 20) @(negedge clk);
      check("frame_to_idle", busy, 0);
      check("frame_to_err", err_cnt, model_err[7:0]);
      run_frame(1, 8'h00, 8'h00, 1);

      // Inter-byte gaps just under the frame timeout are tolerated.
      cur_delay = 2;
      expect_bus(8'h33, 1'b1, 8'h5A);
      model_mem[8'h33] = 8'h5A;
      expect_tx(8'h06);
      rx_fifo.push_back(8'h57);
      repeat (FrameTo - 10) @(negedge clk);
      rx_fifo.push_back(8'h33);
      repeat (FrameTo - 10) @(negedge clk);
      rx_fifo.push_back(8'h5A);
      wait_done(600, "gap_frame_done");

      // Bus never acks: NAK after BUS_TO; ack in the final cycle still wins.
      run_frame(1, 8'h05, 8'h00, Never);
      run_frame(0, 8'h06, 8'hC3, BusTo - 1);
      run_frame(1, 8'h06, 8'h00, BusTo - 1);
      run_frame(1, 8'h07, 8'h00, BusTo);

      // TX FIFO full holds the response.
      full_force = 1'b1;
      issue_frame(2, 8'h00, 8'h41, 0);
      repeat (50) @(negedge clk);
      check("full_hold_busy", busy, 1);
      check("full_hold_pending", tx_q.size(), 1);
      full_force = 1'b0;
      wait_done(100, "full_release_done");

      // Reset mid-frame: no response.
      rx_fifo.push_back(8'h57);
      rx_fifo.push_back(8'h10);
      repeat (8) @(negedge clk);
      check("busy_mid_frame", busy, 1);
      apply_reset();
      repeat (10) @(negedge clk);
      check("no_resp_after_reset", tx_q.size(), 0);

      // Status byte with err_cnt = 3.
      for (int i = 0; i < 3; i++) run_frame(2, 8'h00, 8'h41, 0);
      check("err_before_status", err_cnt, 3);
      run_frame(2, 8'h00, 8'h53, 0);
      check("err_after_status", err_cnt, model_err[7:0]);

      // Randomized frames with TX back-pressure.
      full_rand = 1'b1;
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 2);
         a    = 8'($urandom_range(0, 15));
         d    = 8'($urandom);
         if (kind == 2 && (d == 8'h57 || d == 8'h52)) d = 8'h41;
         r    = $urandom_range(0, 9);
         dly  = (r < 7) ? r : (r == 7) ? BusTo - 1 : (r == 8) ? BusTo : Never;
         run_frame(kind, a, d, dly);
      end
      full_rand = 1'b0;
      check("err_after_random", err_cnt, model_err[7:0]);

      // Back-to-back unknown bytes drive err_cnt into saturation.
      for (int i = 0; i < 260; i++) issue_frame(2, 8'h00, 8'h41, 0);
      wait_done(4000, "burst_done");
      check("err_saturated", err_cnt, model_err[7:0]);
      run_frame(2, 8'h00, 8'h53, 0);
      check("err_final", err_cnt, model_err[7:0]);

      repeat (10) @(negedge clk);
      check("tx_queue_drained", tx_q.size(), 0);
      check("bus_queue_drained", bus_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
